// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM states, access-size codes and the IO window base.
// Imported by the controller so the cache/LSB side can use the same size encodings.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IF_RD,
      ST_LS_RD,
      ST_LS_WR
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

   localparam logic [2:0] IF_LEN = 3'd4;

   // The reserved size code 3 behaves like a word access.
   function automatic logic [2:0] size_to_len(input logic [1:0] size);
      case (size)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-side responder that serialises i_cache fills and load/store accesses onto the
// 8-bit RAM/IO bus one byte per cycle and returns little-endian assembled data.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IO_BASE_DEFAULT)
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  if_valid_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   output logic                  if_done_out,
   output logic [31:0]           if_data_out,
   input  logic                  ls_valid_in,
   input  logic                  ls_wr_in,
   input  logic [1:0]            ls_size_in,
   input  logic [ADDR_WIDTH-1:0] ls_addr_in,
   input  logic [31:0]           ls_data_in,
   output logic                  ls_done_out,
   output logic [31:0]           ls_data_out,
   input  logic [7:0]            mem_din_in,
   output logic [7:0]            mem_dout_out,
   output logic [ADDR_WIDTH-1:0] mem_a_out,
   output logic                  mem_wr_out,
   input  logic                  io_buffer_full_in
);

   state_t                state;
   logic [2:0]            step;
   logic [2:0]            len;
   logic [ADDR_WIDTH-1:0] base;
   logic [31:0]           wdata;
   logic [31:0]           gather;

   logic [31:0]           gather_next;
   logic [ADDR_WIDTH-1:0] rd_next_addr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  base_is_io;
   logic                  accept_ls;
   logic                  accept_if;
   logic                  ls_stall_now;

   // In a read, step counts edges since accept; the byte addressed at step-1 edges
   // earlier arrives now because the RAM returns data one cycle after the address.
   always_comb begin
      gather_next = gather;
      case (step)
         3'd1:    gather_next[7:0]   = mem_din_in;
         3'd2:    gather_next[15:8]  = mem_din_in;
         3'd3:    gather_next[23:16] = mem_din_in;
         3'd4:    gather_next[31:24] = mem_din_in;
         default: gather_next = gather;
      endcase
   end

   assign rd_next_addr = base + ADDR_WIDTH'({1'b0, step} + 4'd1);
   assign wr_addr      = base + ADDR_WIDTH'(step);
   assign base_is_io   = (base >= IO_BASE);
   assign ls_stall_now = (ls_addr_in >= IO_BASE) && io_buffer_full_in;

   // A requester drops valid in the cycle its done is high, so that cycle must not re-accept.
   assign accept_ls = ls_valid_in && !ls_done_out;
   assign accept_if = if_valid_in && !if_done_out;

   // Single FSM; in a write, step counts bytes already issued so IO stalls simply hold it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         step         <= 3'd0;
         len          <= 3'd0;
         base         <= '0;
         wdata        <= 32'h0;
         gather       <= 32'h0;
         if_done_out  <= 1'b0;
         if_data_out  <= 32'h0;
         ls_done_out  <= 1'b0;
         ls_data_out  <= 32'h0;
         mem_dout_out <= 8'h00;
         mem_a_out    <= '0;
         mem_wr_out   <= 1'b0;
      end else if (rdy_in) begin
         if_done_out <= 1'b0;
         ls_done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               mem_wr_out <= 1'b0;
               if (!clear_in) begin
                  if (accept_ls) begin
                     base      <= ls_addr_in;
                     len       <= size_to_len(ls_size_in);
                     mem_a_out <= ls_addr_in;
                     gather    <= 32'h0;
                     if (ls_wr_in) begin
                        state <= ST_LS_WR;
                        if (ls_stall_now) begin
                           step  <= 3'd0;
                           wdata <= ls_data_in;
                        end else begin
                           step         <= 3'd1;
                           mem_dout_out <= ls_data_in[7:0];
                           mem_wr_out   <= 1'b1;
                           wdata        <= {8'h00, ls_data_in[31:8]};
                        end
                     end else begin
                        state <= ST_LS_RD;
                        step  <= 3'd0;
                     end
                  end else if (accept_if) begin
                     state     <= ST_IF_RD;
                     base      <= if_addr_in;
                     len       <= IF_LEN;
                     mem_a_out <= if_addr_in;
                     gather    <= 32'h0;
                     step      <= 3'd0;
                  end
               end
            end

            ST_IF_RD, ST_LS_RD: begin
               if (clear_in) begin
                  state <= ST_IDLE;
               end else begin
                  step <= step + 3'd1;
                  if ((step + 3'd1) < len) begin
                     mem_a_out <= rd_next_addr;
                  end
                  if (step != 3'd0) begin
                     gather <= gather_next;
                  end
                  if (step == len) begin
                     state <= ST_IDLE;
                     if (state == ST_IF_RD) begin
                        if_done_out <= 1'b1;
                        if_data_out <= gather_next;
                     end else begin
                        ls_done_out <= 1'b1;
                        ls_data_out <= gather_next;
                     end
                  end
               end
            end

            // Stores ignore clear_in: once committed they must reach memory.
            ST_LS_WR: begin
               if (step == len) begin
                  mem_wr_out  <= 1'b0;
                  ls_done_out <= 1'b1;
                  state       <= ST_IDLE;
               end else if (base_is_io && io_buffer_full_in) begin
                  mem_wr_out <= 1'b0;
               end else begin
                  mem_a_out    <= wr_addr;
                  mem_dout_out <= wdata[7:0];
                  wdata        <= {8'h00, wdata[31:8]};
                  mem_wr_out   <= 1'b1;
                  step         <= step + 3'd1;
               end
            end

            default: begin
               state      <= ST_IDLE;
               mem_wr_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
